// File: rtl/xor_pkg.sv
// Shared constants for the XOR checksum accumulator.
// State encoding and default data width.
package xor_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/xor_reduce.sv
// Combinational WIDTH-input XOR tree.
// Produces the parity bit of a word.
module xor_reduce
    import xor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    output logic             result
);

    always_comb begin
        result = ^data;
    end

endmodule

// File: rtl/xor_checksum_accum.sv
// Frame-wise XOR checksum with generate/check modes.
// One result per frame through a valid/ready handshake.
module xor_checksum_accum
    import xor_pkg::*;
#(
    parameter  int WIDTH   = DEF_WIDTH,
    parameter  int MAX_LEN = 16,
    localparam int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             check_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_err
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic             mode;
    logic             ovf;
    logic             mismatch;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_fire) state_next = in_last ? DONE : RUN;
            RUN:  if (in_fire && in_last) state_next = DONE;
            DONE: if (out_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Results are exposed only while a frame is complete.
    always_comb begin
        in_ready  = (state != DONE);
        out_valid = (state == DONE);
        out_sum   = out_valid ? acc : '0;
        out_count = out_valid ? count : '0;
        out_err   = out_valid & (ovf | mismatch);
    end

    xor_reduce #(.WIDTH(WIDTH)) u_parity (
        .data   (out_sum),
        .result (out_parity)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            count    <= '0;
            mode     <= 1'b0;
            ovf      <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        mode     <= check_mode;
                        count    <= CW'(1);
                        ovf      <= 1'b0;
                        // A lone check-mode word is compared against zero.
                        acc      <= (check_mode && in_last) ? '0 : in_data;
                        mismatch <= check_mode & in_last & (in_data != '0);
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        if (count != MAX_CNT) count <= count + CW'(1);
                        if (count == MAX_CNT && !in_last) ovf <= 1'b1;
                        if (mode && in_last) begin
                            mismatch <= (acc != in_data);
                        end else begin
                            acc <= acc ^ in_data;
                        end
                    end
                end
                DONE: begin
                    if (out_fire) begin
                        acc      <= '0;
                        count    <= '0;
                        ovf      <= 1'b0;
                        mismatch <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
